// File: rtl/snake_pkg.sv
// Shared types and defaults for the snake head stepper: direction and state
// encodings, the reversal helper and default grid/tick sizes.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    RIGHT = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int DEFAULT_GRID_W   = 16;
  localparam int DEFAULT_GRID_H   = 12;
  localparam int DEFAULT_TICK_DIV = 25_000_000;

  // Opposite directions differ only in the low encoding bit.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_head_stepper_tick_divider.sv
// Game-tick divider: counts enabled clk cycles and pulses tick for one cycle
// when the count reaches TICK_DIV-1; clr holds the count at zero.
module tick_divider
  import snake_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign tick = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snake_head_stepper.sv
// Snake head stepper: validates one-hot direction requests, commits them on
// game ticks and moves the head, flagging walls. Define SNAKE_WRAP_EN to wrap.
module snake_head_stepper
  import snake_pkg::*;
#(
  parameter int GRID_W   = DEFAULT_GRID_W,
  parameter int GRID_H   = DEFAULT_GRID_H,
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run_en,
  input  logic                      dir_up,
  input  logic                      dir_down,
  input  logic                      dir_right,
  input  logic                      dir_left,
  output logic [$clog2(GRID_W)-1:0] head_x,
  output logic [$clog2(GRID_H)-1:0] head_y,
  output logic [1:0]                cur_dir,
  output logic                      step_valid,
  output logic                      running,
  output logic                      game_over
);

  localparam int XW  = $clog2(GRID_W);
  localparam int YW  = $clog2(GRID_H);
  localparam int XW1 = XW + 1;
  localparam int YW1 = YW + 1;
  localparam logic [XW1-1:0] MAX_X = XW1'(GRID_W - 1);
  localparam logic [YW1-1:0] MAX_Y = YW1'(GRID_H - 1);

  state_t        state_q, state_d;
  logic [XW-1:0] head_x_q, head_x_d;
  logic [YW-1:0] head_y_q, head_y_d;
  dir_t          cur_dir_q, cur_dir_d;
  dir_t          pending_dir_q, pending_dir_d;
  logic          step_valid_q, step_valid_d;
  logic          running_q, running_d;
  logic          game_over_q, game_over_d;

  logic          tick_s;
  logic          req_valid_s;
  dir_t          req_dir_s;
  dir_t          next_cur_s;
  logic [XW:0]   nx_s;
  logic [YW:0]   ny_s;
  logic          wall_s;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != RUN),
    .en   (run_en),
    .tick (tick_s)
  );

  always_comb begin
    req_valid_s = 1'b1;
    req_dir_s   = RIGHT;
    case ({dir_up, dir_down, dir_right, dir_left})
      4'b1000: req_dir_s = UP;
      4'b0100: req_dir_s = DOWN;
      4'b0010: req_dir_s = RIGHT;
      4'b0001: req_dir_s = LEFT;
      default: req_valid_s = 1'b0;
    endcase
  end

  // Candidate cell is one bit wider so underflow/overflow show up as out-of-range.
  always_comb begin
    nx_s = {1'b0, head_x_q};
    ny_s = {1'b0, head_y_q};
    case (pending_dir_q)
      UP:      ny_s = {1'b0, head_y_q} - YW1'(1);
      DOWN:    ny_s = {1'b0, head_y_q} + YW1'(1);
      RIGHT:   nx_s = {1'b0, head_x_q} + XW1'(1);
      LEFT:    nx_s = {1'b0, head_x_q} - XW1'(1);
      default: nx_s = {1'b0, head_x_q};
    endcase
    wall_s = (nx_s > MAX_X) || (ny_s > MAX_Y);
  end

`ifdef SNAKE_WRAP_EN
  logic [XW-1:0] wrap_x_s;
  logic [YW-1:0] wrap_y_s;

  always_comb begin
    if (nx_s > MAX_X) begin
      wrap_x_s = (pending_dir_q == LEFT) ? XW'(GRID_W - 1) : '0;
    end else begin
      wrap_x_s = nx_s[XW-1:0];
    end
    if (ny_s > MAX_Y) begin
      wrap_y_s = (pending_dir_q == UP) ? YW'(GRID_H - 1) : '0;
    end else begin
      wrap_y_s = ny_s[YW-1:0];
    end
  end
`endif

  assign next_cur_s = tick_s ? pending_dir_q : cur_dir_q;

  always_comb begin
    state_d       = state_q;
    head_x_d      = head_x_q;
    head_y_d      = head_y_q;
    cur_dir_d     = cur_dir_q;
    pending_dir_d = pending_dir_q;
    step_valid_d  = 1'b0;
    game_over_d   = game_over_q;
    case (state_q)
      IDLE: begin
        if (req_valid_s) begin
          cur_dir_d     = req_dir_s;
          pending_dir_d = req_dir_s;
          state_d       = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (tick_s) begin
          cur_dir_d = pending_dir_q;
          if (!wall_s) begin
            head_x_d     = nx_s[XW-1:0];
            head_y_d     = ny_s[YW-1:0];
            step_valid_d = 1'b1;
          end else begin
`ifdef SNAKE_WRAP_EN
            head_x_d     = wrap_x_s;
            head_y_d     = wrap_y_s;
            step_valid_d = 1'b1;
`else
            game_over_d  = 1'b1;
            state_d      = OVER;
`endif
          end
        end else begin
          cur_dir_d = cur_dir_q;
        end
        // Reversal is judged against the direction that will be committed after this edge.
        if (req_valid_s && (req_dir_s != opposite(next_cur_s))) begin
          pending_dir_d = req_dir_s;
        end else begin
          pending_dir_d = pending_dir_q;
        end
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      head_x_q      <= XW'(GRID_W / 2);
      head_y_q      <= YW'(GRID_H / 2);
      cur_dir_q     <= RIGHT;
      pending_dir_q <= RIGHT;
      step_valid_q  <= 1'b0;
      running_q     <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      head_x_q      <= head_x_d;
      head_y_q      <= head_y_d;
      cur_dir_q     <= cur_dir_d;
      pending_dir_q <= pending_dir_d;
      step_valid_q  <= step_valid_d;
      running_q     <= running_d;
      game_over_q   <= game_over_d;
    end
  end

  assign head_x     = head_x_q;
  assign head_y     = head_y_q;
  assign cur_dir    = cur_dir_q;
  assign step_valid = step_valid_q;
  assign running    = running_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_snake_head_stepper.sv
// Scoreboard bench for snake_head_stepper on an 8x6 grid with TICK_DIV=4:
// stimulus queues expected head moves, a negedge monitor checks each step pulse.
module tb_snake_head_stepper;
  import snake_pkg::*;

  localparam int GW = 8;
  localparam int GH = 6;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run_en = 1'b1;
  logic       du = 1'b0, dd = 1'b0, dr = 1'b0, dl = 1'b0;
  logic [2:0] head_x, head_y;
  logic [1:0] cur_dir;
  logic       step_valid, running, game_over;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
    logic [1:0] d;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  snake_head_stepper #(.GRID_W(GW), .GRID_H(GH), .TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst        (rst),
    .run_en     (run_en),
    .dir_up     (du),
    .dir_down   (dd),
    .dir_right  (dr),
    .dir_left   (dl),
    .head_x     (head_x),
    .head_y     (head_y),
    .cur_dir    (cur_dir),
    .step_valid (step_valid),
    .running    (running),
    .game_over  (game_over)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int x, input int y, input int d);
    exp_t e;
    e.x = 3'(x);
    e.y = 3'(y);
    e.d = 2'(d);
    sb_q.push_back(e);
  endtask

  // Monitor: every step pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (step_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_step", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_head_x", int'(head_x), int'(mon_e.x));
        chk("sb_head_y", int'(head_y), int'(mon_e.y));
        chk("sb_cur_dir", int'(cur_dir), int'(mon_e.d));
      end
    end
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] v);
    {du, dd, dr, dl} = v;
    step_clk();
    {du, dd, dr, dl} = 4'b0000;
  endtask

  task automatic wait_step(input int exp_n, input string name);
    int n = 0;
    do begin
      step_clk();
      n++;
    end while (step_valid !== 1'b1 && n < 20);
    chk(name, n, exp_n);
  endtask

  task automatic chk_reset();
    chk("rst_head_x", int'(head_x), 4);
    chk("rst_head_y", int'(head_y), 3);
    chk("rst_cur_dir", int'(cur_dir), 2);
    chk("rst_running", int'(running), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_step_valid", int'(step_valid), 0);
  endtask

  initial begin
    repeat (2) step_clk();
    chk_reset();
    rst = 1'b0;
    repeat (20) step_clk();
    chk_reset();

    // First request starts the game; steps every TD cycles.
    push(4, 2, 0);
    push(4, 1, 0);
    pulse(4'b1000);
    chk("running_after_req", int'(running), 1);
    wait_step(4, "first_step_latency");
    wait_step(4, "step_period");

    // Turn right, then reject reversal, reject multi-hot, last request wins.
    push(5, 1, 2);
    pulse(4'b0010);
    wait_step(3, "turn_right_step");
    push(6, 1, 2);
    pulse(4'b0001);
    wait_step(3, "reversal_step");
    push(7, 1, 2);
    pulse(4'b1001);
    wait_step(3, "multihot_step");
    push(7, 2, 1);
    pulse(4'b1000);
    pulse(4'b0100);
    wait_step(2, "last_wins_step");

    // Freeze with a request captured during the freeze.
    run_en = 1'b0;
    push(6, 2, 3);
    pulse(4'b0001);
    repeat (9) step_clk();
    chk("freeze_head_x", int'(head_x), 7);
    chk("freeze_head_y", int'(head_y), 2);
    chk("freeze_cur_dir", int'(cur_dir), 1);
    run_en = 1'b1;
    wait_step(4, "freeze_resume");

    push(6, 3, 1);
    pulse(4'b0100);
    wait_step(3, "down_step");
    push(7, 3, 2);
    pulse(4'b0010);
    wait_step(3, "to_edge_step");

`ifdef SNAKE_WRAP_EN
    push(0, 3, 2);
    wait_step(4, "wrap_step");
    chk("wrap_game_over", int'(game_over), 0);
`else
    repeat (4) step_clk();
    chk("wall_game_over", int'(game_over), 1);
    chk("wall_running", int'(running), 0);
    chk("wall_head_x", int'(head_x), 7);
    chk("wall_head_y", int'(head_y), 3);
    pulse(4'b1000);
    repeat (8) step_clk();
    chk("over_cur_dir", int'(cur_dir), 2);
    chk("over_head_x", int'(head_x), 7);
    chk("over_head_y", int'(head_y), 3);
    chk("over_game_over", int'(game_over), 1);
`endif

    rst = 1'b1;
    step_clk();
    chk_reset();
    rst = 1'b0;
    repeat (3) step_clk();

    // Restart, then reset in the middle of a period.
    push(4, 4, 1);
    pulse(4'b0100);
    chk("restart_running", int'(running), 1);
    wait_step(4, "restart_step");
    repeat (2) step_clk();
    rst = 1'b1;
    step_clk();
    chk_reset();
    rst = 1'b0;
    repeat (12) step_clk();
    chk("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
